// File: rtl/motor_speed_sequencer.sv
// Ramp scheduler for the left/right drive-motor speed codes with emergency stop.
// Optional command-silence watchdog is compiled in with `define MSEQ_WATCHDOG_EN.
module motor_speed_sequencer #(
  parameter logic [19:0] RAMP_TICKS = 20'd1000000,
  parameter logic [3:0]  MAX_SPEED  = 4'd10,
  parameter logic [23:0] WDOG_TICKS = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_left,
  input  logic [3:0] cmd_right,
  input  logic       estop,
  output logic [3:0] speed_left,
  output logic [3:0] speed_right,
  output logic       busy,
  output logic       at_target,
  output logic       wdog_trip
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [3:0]  spd_l_q, spd_l_d, spd_r_q, spd_r_d;
  logic [19:0] presc_q, presc_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        at_target_q, at_target_d;
  logic        wdog_trip_q, wdog_trip_d;
  logic        accept_s, tick_s;
  logic [3:0]  sat_l_s, sat_r_s;
`ifdef MSEQ_WATCHDOG_EN
  logic [23:0] wdog_cnt_q, wdog_cnt_d;
`else
  logic        wdog_unused_s;
  assign wdog_unused_s = ^WDOG_TICKS;
`endif

  function automatic logic [3:0] sat_f(input logic [3:0] v);
    logic [3:0] r;
    if (v > MAX_SPEED) r = MAX_SPEED;
    else r = v;
    return r;
  endfunction

  function automatic logic [3:0] step_f(input logic [3:0] cur, input logic [3:0] tgt);
    logic [3:0] r;
    if (cur < tgt) r = cur + 4'd1;
    else if (cur > tgt) r = cur - 4'd1;
    else r = cur;
    return r;
  endfunction

  assign accept_s = cmd_valid & cmd_ready_q;
  assign tick_s   = (presc_q == (RAMP_TICKS - 20'd1));
  assign sat_l_s  = sat_f(cmd_left);
  assign sat_r_s  = sat_f(cmd_right);

  // Next-state logic: estop first, then per-state ramp control, then watchdog override.
  always_comb begin
    state_d     = state_q;
    tgt_l_d     = tgt_l_q;
    tgt_r_d     = tgt_r_q;
    spd_l_d     = spd_l_q;
    spd_r_d     = spd_r_q;
    presc_d     = presc_q;
    wdog_trip_d = wdog_trip_q;
`ifdef MSEQ_WATCHDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
`endif
    if (estop) begin
      state_d = S_STOP;
      tgt_l_d = 4'd0;
      tgt_r_d = 4'd0;
      spd_l_d = 4'd0;
      spd_r_d = 4'd0;
      presc_d = 20'd0;
`ifdef MSEQ_WATCHDOG_EN
      wdog_cnt_d = 24'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            tgt_l_d = sat_l_s;
            tgt_r_d = sat_r_s;
            presc_d = 20'd0;
            if ((sat_l_s != spd_l_q) || (sat_r_s != spd_r_q)) state_d = S_RAMP;
            else state_d = S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RAMP: begin
          // The step always uses the targets held before this edge.
          if (tick_s) begin
            presc_d = 20'd0;
            spd_l_d = step_f(spd_l_q, tgt_l_q);
            spd_r_d = step_f(spd_r_q, tgt_r_q);
          end else begin
            presc_d = presc_q + 20'd1;
          end
          if (accept_s) begin
            tgt_l_d = sat_l_s;
            tgt_r_d = sat_r_s;
          end else begin
            tgt_l_d = tgt_l_q;
            tgt_r_d = tgt_r_q;
          end
          if (tick_s && (spd_l_d == tgt_l_d) && (spd_r_d == tgt_r_d)) state_d = S_IDLE;
          else state_d = S_RAMP;
        end
        S_STOP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
`ifdef MSEQ_WATCHDOG_EN
      if (accept_s) begin
        wdog_cnt_d  = 24'd0;
        wdog_trip_d = 1'b0;
      end else if (state_q == S_STOP) begin
        wdog_cnt_d = 24'd0;
      end else if (wdog_cnt_q == (WDOG_TICKS - 24'd1)) begin
        wdog_cnt_d  = 24'd0;
        tgt_l_d     = 4'd0;
        tgt_r_d     = 4'd0;
        state_d     = S_RAMP;
        wdog_trip_d = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 24'd1;
      end
`else
      wdog_trip_d = 1'b0;
`endif
    end
    cmd_ready_d = (state_d != S_STOP);
    busy_d      = (state_d == S_RAMP);
    at_target_d = (state_d == S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tgt_l_q     <= 4'd0;
      tgt_r_q     <= 4'd0;
      spd_l_q     <= 4'd0;
      spd_r_q     <= 4'd0;
      presc_q     <= 20'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
      wdog_trip_q <= 1'b0;
`ifdef MSEQ_WATCHDOG_EN
      wdog_cnt_q  <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      tgt_l_q     <= tgt_l_d;
      tgt_r_q     <= tgt_r_d;
      spd_l_q     <= spd_l_d;
      spd_r_q     <= spd_r_d;
      presc_q     <= presc_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
      wdog_trip_q <= wdog_trip_d;
`ifdef MSEQ_WATCHDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign speed_left  = spd_l_q;
  assign speed_right = spd_r_q;
  assign busy        = busy_q;
  assign at_target   = at_target_q;
  assign wdog_trip   = wdog_trip_q;

endmodule
